// File: rtl/ber_checker.sv
// Bit-error-rate checker: sweeps candidate link delays between the reference PRBS
// stream and the received stream, locks to the best delay, then counts bits and errors.
module ber_checker #(
    parameter int MAX_DELAY = 511,
    parameter int NB_DELAY  = 9,
    parameter int SYNC_LEN  = 511,
    parameter int NB_SYNC   = 9,
    parameter int NB_COUNT  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                resync,
    input  logic                bit_ref,
    input  logic                bit_rx,
    output logic                locked,
    output logic [NB_DELAY-1:0] delay_out,
    output logic [NB_COUNT-1:0] bit_count,
    output logic [NB_COUNT-1:0] error_count,
    output logic [1:0]          state_dbg
);

    // enable is a sample strobe without back-pressure: every cycle with enable high
    // consumes exactly one bit_ref/bit_rx pair; the block never stalls its source.
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SWEEP = 2'd1,
        COUNT = 2'd2
    } state_t;

    localparam logic [NB_DELAY-1:0] LAST_DELAY = NB_DELAY'(MAX_DELAY - 1);
    localparam logic [NB_SYNC-1:0]  SYNC_LAST  = NB_SYNC'(SYNC_LEN - 1);

    state_t               state_q;
    state_t               state_d;
    logic [MAX_DELAY-1:0] dline;
    logic [NB_DELAY-1:0]  fill_cnt;
    logic [NB_DELAY-1:0]  trial_d;
    logic [NB_SYNC-1:0]   trial_samples;
    logic [NB_SYNC-1:0]   trial_err;
    logic [NB_SYNC-1:0]   best_err;
    logic [NB_DELAY-1:0]  best_delay;

    logic                 fill_done;
    logic                 trial_done;
    logic                 sweep_done;
    logic [NB_DELAY-1:0]  tap_d;
    logic [NB_DELAY-1:0]  tap_idx;
    logic                 tap_bit;
    logic                 mismatch;
    logic [NB_SYNC-1:0]   trial_total;
    logic                 better;

    // Tap 0 is the live reference input; tap d>=1 is the bit shifted in d samples ago.
    always_comb begin
        tap_d       = (state_q == COUNT) ? delay_out : trial_d;
        tap_idx     = tap_d - 1'b1;
        tap_bit     = (tap_d == '0) ? bit_ref : dline[tap_idx];
        mismatch    = bit_rx ^ tap_bit;
        trial_total = trial_err + NB_SYNC'(mismatch);
        better      = trial_total < best_err;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_done  = 1'b0;
        trial_done = 1'b0;
        sweep_done = 1'b0;
        if (resync) begin
            state_d = FILL;
        end else if (enable) begin
            case (state_q)
                FILL: begin
                    if (fill_cnt == LAST_DELAY) begin
                        fill_done = 1'b1;
                        state_d   = SWEEP;
                    end
                end
                SWEEP: begin
                    if (trial_samples == SYNC_LAST) begin
                        trial_done = 1'b1;
                        if (trial_d == LAST_DELAY) begin
                            sweep_done = 1'b1;
                            state_d    = COUNT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dline         <= '0;
            fill_cnt      <= '0;
            trial_d       <= '0;
            trial_samples <= '0;
            trial_err     <= '0;
            best_err      <= '1;
            best_delay    <= '0;
            delay_out     <= '0;
            bit_count     <= '0;
            error_count   <= '0;
        end else begin
            if (enable) begin
                dline <= {dline[MAX_DELAY-2:0], bit_ref};
            end
            // resync restarts acquisition but keeps the delay line history.
            if (resync) begin
                fill_cnt      <= '0;
                trial_d       <= '0;
                trial_samples <= '0;
                trial_err     <= '0;
                best_err      <= '1;
                best_delay    <= '0;
                delay_out     <= '0;
                bit_count     <= '0;
                error_count   <= '0;
            end else if (enable) begin
                case (state_q)
                    FILL: begin
                        fill_cnt      <= fill_done ? '0 : fill_cnt + 1'b1;
                        trial_d       <= '0;
                        trial_samples <= '0;
                        trial_err     <= '0;
                    end
                    SWEEP: begin
                        if (trial_done) begin
                            trial_samples <= '0;
                            trial_err     <= '0;
                            trial_d       <= sweep_done ? '0 : trial_d + 1'b1;
                            // Strict compare keeps the lower delay on ties.
                            if (better) begin
                                best_err   <= trial_total;
                                best_delay <= trial_d;
                            end
                            if (sweep_done) begin
                                delay_out   <= better ? trial_d : best_delay;
                                bit_count   <= '0;
                                error_count <= '0;
                            end
                        end else begin
                            trial_samples <= trial_samples + 1'b1;
                            trial_err     <= trial_total;
                        end
                    end
                    COUNT: begin
                        if (bit_count != '1) begin
                            bit_count <= bit_count + 1'b1;
                        end
                        if (mismatch && (error_count != '1)) begin
                            error_count <= error_count + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign locked    = (state_q == COUNT);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ber_checker.sv
// Randomized bench for ber_checker: a history-based reference model predicts the
// registered outputs after every edge; a negedge monitor compares them.
module tb_ber_checker;

    localparam int M    = 16;
    localparam int NB_D = 4;
    localparam int S    = 64;
    localparam int NB_S = 7;
    localparam int NB_C = 10;
    localparam int W    = 1 + NB_D + 2 * NB_C;
    localparam int ACQ  = M + M * S;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            enable = 1'b0;
    logic            resync = 1'b0;
    logic            bit_ref = 1'b0;
    logic            bit_rx = 1'b0;
    logic            locked;
    logic [NB_D-1:0] delay_out;
    logic [NB_C-1:0] bit_count;
    logic [NB_C-1:0] error_count;
    logic [1:0]      state_dbg;

    ber_checker #(
        .MAX_DELAY(M), .NB_DELAY(NB_D), .SYNC_LEN(S), .NB_SYNC(NB_S), .NB_COUNT(NB_C)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .resync(resync),
        .bit_ref(bit_ref), .bit_rx(bit_rx), .locked(locked),
        .delay_out(delay_out), .bit_count(bit_count), .error_count(error_count),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    bit              ref_h[$];
    bit              rx_h[$];
    int              rst_base = 0;
    int              acq_base = 0;
    logic            m_locked = 1'b0;
    logic [NB_D-1:0] m_delay = '0;
    logic [NB_C-1:0] m_bc = '0;
    logic [NB_C-1:0] m_ec = '0;
    logic [W-1:0]    exp_q[$];

    int link = 5;
    bit rx_const0 = 1'b0;
    bit inv_all = 1'b0;

    function automatic bit tap(int d, int g);
        if (d == 0) return ref_h[g];
        if (g - d < rst_base) return 1'b0;
        return ref_h[g - d];
    endfunction

    task automatic model_clear();
        m_locked = 1'b0;
        m_delay  = '0;
        m_bc     = '0;
        m_ec     = '0;
    endtask

    task automatic model_step(input bit en, input bit rs, input bit r, input bit x);
        int g;
        int k;
        int e;
        int best_e;
        int best;
        if (en) begin
            ref_h.push_back(r);
            rx_h.push_back(x);
            g = ref_h.size() - 1;
            k = g - acq_base;
            if (k == ACQ - 1) begin
                best_e = (1 << NB_S) - 1;
                best   = 0;
                for (int d = 0; d < M; d++) begin
                    e = 0;
                    for (int j = 0; j < S; j++) begin
                        if (rx_h[acq_base + M + d * S + j] != tap(d, acq_base + M + d * S + j)) e++;
                    end
                    if (e < best_e) begin
                        best_e = e;
                        best   = d;
                    end
                end
                m_locked = 1'b1;
                m_delay  = NB_D'(best);
                m_bc     = '0;
                m_ec     = '0;
            end else if (k >= ACQ) begin
                if (m_bc != '1) m_bc = m_bc + 1'b1;
                if ((x != tap(int'(m_delay), g)) && (m_ec != '1)) m_ec = m_ec + 1'b1;
            end
        end
        if (rs) begin
            acq_base = ref_h.size();
            model_clear();
        end
        exp_q.push_back({m_locked, m_delay, m_bc, m_ec});
    endtask

    // ---------------- checks ----------------
    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({locked, delay_out, bit_count, error_count} !== e) begin
                n_errors++;
                if (n_errors <= 20)
                    $display("FAIL scoreboard @%0t: got locked=%0d delay=%0d bits=%0d errs=%0d, expected locked=%0d delay=%0d bits=%0d errs=%0d",
                             $time, locked, delay_out, bit_count, error_count,
                             e[W-1], e[W-2 -: NB_D], e[2*NB_C-1 -: NB_C], e[NB_C-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit en, input bit rs, input bit flip);
        bit r;
        bit x;
        int idx;
        r = 1'($urandom_range(0, 1));
        if (rx_const0) begin
            x = 1'b0;
        end else if (link == 0) begin
            x = r;
        end else begin
            idx = ref_h.size() - link;
            x = (idx >= 0) ? ref_h[idx] : 1'b0;
        end
        x = x ^ flip ^ inv_all;
        enable  = en;
        resync  = rs;
        bit_ref = r;
        bit_rx  = x;
        @(posedge clk);
        model_step(en, rs, r, x);
        #1;
        resync = 1'b0;
    endtask

    task automatic run_until_locked(input bit gated, output int edges);
        bit en;
        en = 1'b1;
        edges = 0;
        while (locked !== 1'b1 && edges < 5000) begin
            drive(en, 1'b0, 1'b0);
            edges++;
            if (gated) en = ~en;
        end
        if (locked !== 1'b1) check("lock_timeout", locked, 1);
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_locked", locked, 0);
        check("rst_delay", delay_out, 0);
        check("rst_bits", bit_count, 0);
        check("rst_errs", error_count, 0);
        rst_base = ref_h.size();
        acq_base = ref_h.size();
        model_clear();
        repeat (ncyc) begin
            @(posedge clk);
            exp_q.push_back('0);
        end
        #1;
        rst = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int edges;
        repeat (3) @(posedge clk);
        #1;
        check("reset_locked", locked, 0);
        check("reset_delay", delay_out, 0);
        check("reset_bits", bit_count, 0);
        check("reset_errs", error_count, 0);
        check("reset_state", state_dbg, 0);
        rst = 1'b1;

        // Aligned lock to a 5-sample link delay.
        link = 5;
        run_until_locked(1'b0, edges);
        check("lock_cycles", edges + 1, M + M * S + 1);
        check("lock_delay", delay_out, 5);
        repeat (1000) drive(1'b1, 1'b0, 1'b0);
        check("aligned_bits", bit_count, 1000);
        check("aligned_errs", error_count, 0);

        // Resync while locked, then error injection after relock.
        drive(1'b1, 1'b1, 1'b0);
        check("resync_locked", locked, 0);
        check("resync_bits", bit_count, 0);
        check("resync_delay", delay_out, 0);
        run_until_locked(1'b0, edges);
        check("resync_lock_cycles", edges, ACQ);
        check("resync_delay_relock", delay_out, 5);
        for (int i = 0; i < 200; i++) drive(1'b1, 1'b0, (i == 40) || (i == 100) || (i == 170));
        check("inject_bits", bit_count, 200);
        check("inject_errs", error_count, 3);

        // Reset in the middle of the sweep.
        drive(1'b1, 1'b1, 1'b0);
        repeat (M + 100) drive(1'b1, 1'b0, 1'b0);
        do_reset(3);
        run_until_locked(1'b0, edges);
        check("rst_lock_cycles", edges, ACQ);
        check("rst_relock_delay", delay_out, 5);

        // Resync on the very last sweep sample must prevent lock.
        drive(1'b1, 1'b1, 1'b0);
        repeat (ACQ - 1) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        check("final_resync_locked", locked, 0);
        run_until_locked(1'b0, edges);
        check("final_resync_relock", edges, ACQ);

        // No-sync: constant zero received stream.
        rx_const0 = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        run_until_locked(1'b0, edges);
        check("nosync_delay", delay_out, m_delay);
        repeat (300) drive(1'b1, 1'b0, 1'b0);
        check("nosync_half", (error_count > bit_count / 3) && (error_count < 2 * bit_count / 3), 1);
        rx_const0 = 1'b0;

        // Enable gating with zero link delay.
        link = 0;
        drive(1'b1, 1'b1, 1'b0);
        run_until_locked(1'b1, edges);
        check("gated_lock_cycles", edges, 2 * ACQ - 1);
        check("gated_delay", delay_out, 0);
        for (int i = 0; i < 20; i++) drive(i[0], 1'b0, 1'b0);
        check("gated_bits", bit_count, 10);

        // Saturation with every received bit inverted after lock.
        link = 5;
        drive(1'b1, 1'b1, 1'b0);
        run_until_locked(1'b0, edges);
        inv_all = 1'b1;
        repeat (1100) drive(1'b1, 1'b0, 1'b0);
        check("sat_bits", bit_count, (1 << NB_C) - 1);
        check("sat_errs", error_count, (1 << NB_C) - 1);
        inv_all = 1'b0;

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
